// File: rtl/mc_pkg.sv
// Shared types, opcodes and select encodings for the multicycle RV32I controller.
// state_ctrl gives the static (Moore) control word for each FSM state.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       fetch_en;
    logic       beq_en;
    logic       jal_en;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       halted;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_req = 1'b1; c.fetch_en = 1'b1;
                      c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
                      c.result_src = RES_ALURESULT; end
      DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      MEMADR:   begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_IMM; end
      MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
      EXECR:    begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_REGB; end
      EXECI:    begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_IMM; end
      ALUWB:    begin c.reg_write = 1'b1; end
      BEQ:      begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_REGB; c.beq_en = 1'b1; end
      JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.jal_en = 1'b1; end
      HALT:     begin c.halted = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_src_of(logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// Control/datapath bundle between the multicycle controller (master) and the datapath (slave).
interface mc_if;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       EQ;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUctrl;

  modport master (
    input  Op, funct3, funct7_5, EQ, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUctrl
  );

  modport slave (
    output Op, funct3, funct7_5, EQ, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUctrl
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU function decoder: maps ALUOp plus instruction fields to an ALU control code.
// illegal flags funct3 values outside the supported ALU subset.
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: illegal = 1'b0;
      default:                        illegal = 1'b1;
    endcase
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5 set) can encode sub; addi ignores Instr[30].
          3'b000:  alu_ctrl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing FSM for the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Control word is registered from the next state; handshake-dependent enables are gated at the output.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mc_if.master                 bus,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [2:0]           alu_ctrl_q, alu_ctrl_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  alu_op_t              dec_alu_op;
  logic [2:0]           dec_alu_ctrl;
  logic                 dec_illegal;

  always_comb begin
    dec_alu_op = ALUOP_ADD;
    if (state_q == DECODE) begin
      if (bus.Op == OP_RTYPE || bus.Op == OP_ITYPE) dec_alu_op = ALUOP_FUNCT;
      else if (bus.Op == OP_BRANCH)                 dec_alu_op = ALUOP_SUB;
    end
  end

  mc_alu_dec u_alu_dec (
    .alu_op   (dec_alu_op),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .op5      (bus.Op[5]),
    .alu_ctrl (dec_alu_ctrl),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_LOAD, OP_STORE: state_d = (bus.funct3 == F3_WORD) ? MEMADR : HALT;
          OP_RTYPE:          state_d = dec_illegal ? HALT : EXECR;
          OP_ITYPE:          state_d = dec_illegal ? HALT : EXECI;
          OP_BRANCH:         state_d = (bus.funct3 == F3_BEQ) ? BEQ : HALT;
          OP_JAL:            state_d = JAL;
          default:           state_d = HALT;
        endcase
      end
      MEMADR:   state_d = (bus.Op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      HALT:     state_d = HALT;
      default:  state_d = HALT;
    endcase
  end

  // ALU code is only decoded while leaving DECODE; the instruction register is stable then.
  always_comb begin
    ctrl_d     = state_ctrl(state_d);
    alu_ctrl_d = ALU_ADD;
    if (state_d == EXECR || state_d == EXECI || state_d == BEQ) alu_ctrl_d = dec_alu_ctrl;
    instret_d = instret_q;
    if (state_d == FETCH &&
        (state_q == MEMWB || state_q == MEMWRITE || state_q == ALUWB || state_q == BEQ))
      instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      ctrl_q     <= state_ctrl(FETCH);
      alu_ctrl_q <= ALU_ADD;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_ctrl_d;
      instret_q  <= instret_d;
    end
  end

  assign bus.mem_req   = rst_n & ctrl_q.mem_req;
  assign bus.AdrSrc    = ctrl_q.adr_src;
  assign bus.MemWrite  = rst_n & ctrl_q.mem_write;
  assign bus.IRWrite   = rst_n & ctrl_q.fetch_en & bus.mem_ready;
  assign bus.PCWrite   = rst_n & ((ctrl_q.fetch_en & bus.mem_ready) |
                                  (ctrl_q.beq_en & bus.EQ) | ctrl_q.jal_en);
  assign bus.RegWrite  = rst_n & ctrl_q.reg_write;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.ALUSrcA   = ctrl_q.alu_src_a;
  assign bus.ALUSrcB   = ctrl_q.alu_src_b;
  assign bus.ImmSrc    = imm_src_of(bus.Op);
  assign bus.ALUctrl   = alu_ctrl_q;
  assign halted        = rst_n & ctrl_q.halted;
  assign instret       = instret_q;

endmodule
